// File: rtl/vga_sync_gen_if.sv
// Pixel-side bundle of the VGA timing generator: enable/pixel in, coordinates, syncs and flags out.
// o_FrameCount exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
);
  logic             i_Enable;
  logic             i_Video;
  logic [CNT_W-1:0] o_X;
  logic [CNT_W-1:0] o_Y;
  logic             o_HSync;
  logic             o_VSync;
  logic             o_HBlank;
  logic             o_VBlank;
  logic             o_Active;
  logic             o_LineStart;
  logic             o_FrameStart;
  logic             o_Video;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0]      o_FrameCount;
`endif

  modport master (
    input  i_Enable, i_Video,
    output o_X, o_Y, o_HSync, o_VSync, o_HBlank, o_VBlank,
    output o_Active, o_LineStart, o_FrameStart, o_Video
`ifdef VGA_SYNC_FRAME_CNT_EN
    , output o_FrameCount
`endif
  );

  modport slave (
    output i_Enable, i_Video,
    input  o_X, o_Y, o_HSync, o_VSync, o_HBlank, o_VBlank,
    input  o_Active, o_LineStart, o_FrameStart, o_Video
`ifdef VGA_SYNC_FRAME_CNT_EN
    , input o_FrameCount
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: zero-based pixel/line counters with registered, zero-skew sync and blank flags.
// Optional 16-bit frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int CNT_W      = 10,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  vga_sync_gen_if.master    bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_zero
    $error("vga_sync_gen: timing parameters must all be non-zero");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] x_q, y_q, x_nxt, y_nxt;
  logic             hsync_q, vsync_q, hblank_q, vblank_q, active_q;
  logic             line_start_q, frame_start_q;

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (bus.i_Enable) begin
      if (x_q == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_nxt = x_q + CNT_W'(1);
      end
    end
  end

  // Flags are derived from the next coordinate so they land on the same edge as o_X/o_Y.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      hsync_q       <= (x_nxt >= H_SYNC_START && x_nxt < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_q       <= (y_nxt >= V_SYNC_START && y_nxt < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
      hblank_q      <= (x_nxt >= H_VIS_END);
      vblank_q      <= (y_nxt >= V_VIS_END);
      active_q      <= (x_nxt < H_VIS_END) && (y_nxt < V_VIS_END);
      line_start_q  <= (x_nxt == '0);
      frame_start_q <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_wrap;

  assign frame_wrap = bus.i_Enable && (x_q == H_LAST) && (y_q == V_LAST);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.o_FrameCount = frame_cnt_q;
`endif

  assign bus.o_X          = x_q;
  assign bus.o_Y          = y_q;
  assign bus.o_HSync      = hsync_q;
  assign bus.o_VSync      = vsync_q;
  assign bus.o_HBlank     = hblank_q;
  assign bus.o_VBlank     = vblank_q;
  assign bus.o_Active     = active_q;
  assign bus.o_LineStart  = line_start_q;
  assign bus.o_FrameStart = frame_start_q;
  assign bus.o_Video      = active_q & bus.i_Video;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default-timing instance for line-level checks and a tiny-timing instance
// (15x8 raster, HSync active-high) for frame, stall and async-reset checks.
module tb_vga_sync_gen;

  logic i_Clk = 1'b0;
  logic rst_def, rst_sm;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 i_Clk = ~i_Clk;

  vga_sync_gen_if #(.CNT_W(10)) if_def ();
  vga_sync_gen_if #(.CNT_W(4))  if_sm ();

  vga_sync_gen u_def (
    .i_Clk   (i_Clk),
    .i_Reset (rst_def),
    .bus     (if_def.master)
  );

  vga_sync_gen #(
    .CNT_W(4),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) u_sm (
    .i_Clk   (i_Clk),
    .i_Reset (rst_sm),
    .bus     (if_sm.master)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // small-instance reference coordinate and frame count
  int sx, sy, sfc;

  task automatic sm_advance();
    if (sx == 14) begin
      sx = 0;
      if (sy == 7) begin
        sy  = 0;
        sfc = (sfc + 1) % 65536;
      end else begin
        sy++;
      end
    end else begin
      sx++;
    end
  endtask

  task automatic sm_check_all(input string tag);
    int ehs, evs, ehb, evb, eact;
    ehb  = (sx >= 8) ? 1 : 0;
    evb  = (sy >= 4) ? 1 : 0;
    eact = (ehb == 0 && evb == 0) ? 1 : 0;
    ehs  = (sx >= 10 && sx < 13) ? 1 : 0;
    evs  = (sy >= 5 && sy < 7) ? 0 : 1;
    chk({tag, ".x"},      32'(if_sm.o_X), sx);
    chk({tag, ".y"},      32'(if_sm.o_Y), sy);
    chk({tag, ".hsync"},  32'(if_sm.o_HSync), ehs);
    chk({tag, ".vsync"},  32'(if_sm.o_VSync), evs);
    chk({tag, ".hblank"}, 32'(if_sm.o_HBlank), ehb);
    chk({tag, ".vblank"}, 32'(if_sm.o_VBlank), evb);
    chk({tag, ".active"}, 32'(if_sm.o_Active), eact);
    chk({tag, ".lstart"}, 32'(if_sm.o_LineStart), (sx == 0) ? 1 : 0);
    chk({tag, ".fstart"}, 32'(if_sm.o_FrameStart), (sx == 0 && sy == 0) ? 1 : 0);
    chk({tag, ".video"},  32'(if_sm.o_Video), eact & 32'(if_sm.i_Video));
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk({tag, ".fcount"}, 32'(if_sm.o_FrameCount), sfc);
`endif
  endtask

  initial begin
    int ex, ey, pulses, first_fs;
    rst_def = 1'b1;
    rst_sm  = 1'b1;
    if_def.i_Enable = 1'b0;
    if_def.i_Video  = 1'b1;
    if_sm.i_Enable  = 1'b0;
    if_sm.i_Video   = 1'b1;
    sx = 0; sy = 0; sfc = 0;
    repeat (2) tick();

    // reset state, default polarity (active-low syncs idle high)
    chk("rst.def.x",      32'(if_def.o_X), 0);
    chk("rst.def.y",      32'(if_def.o_Y), 0);
    chk("rst.def.hsync",  32'(if_def.o_HSync), 1);
    chk("rst.def.vsync",  32'(if_def.o_VSync), 1);
    chk("rst.def.hblank", 32'(if_def.o_HBlank), 0);
    chk("rst.def.vblank", 32'(if_def.o_VBlank), 0);
    chk("rst.def.active", 32'(if_def.o_Active), 1);
    chk("rst.def.lstart", 32'(if_def.o_LineStart), 1);
    chk("rst.def.fstart", 32'(if_def.o_FrameStart), 1);
    chk("rst.def.video",  32'(if_def.o_Video), 1);
    chk("rst.sm.hsync",   32'(if_sm.o_HSync), 0);
    sm_check_all("rst.sm");

    // one full default line with enable held high
    rst_def = 1'b0;
    if_def.i_Enable = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      ex = k % 800;
      ey = k / 800;
      chk("line.x",      32'(if_def.o_X), ex);
      chk("line.y",      32'(if_def.o_Y), ey);
      chk("line.hsync",  32'(if_def.o_HSync), (ex >= 656 && ex <= 751) ? 0 : 1);
      chk("line.hblank", 32'(if_def.o_HBlank), (ex >= 640) ? 1 : 0);
      chk("line.active", 32'(if_def.o_Active), (ex < 640) ? 1 : 0);
      chk("line.video",  32'(if_def.o_Video), (ex < 640) ? 1 : 0);
      chk("line.vsync",  32'(if_def.o_VSync), 1);
      if (if_def.o_LineStart) pulses++;
    end
    chk("line.pulses", pulses, 1);

    // stall on the default instance: everything frozen at (0,1)
    if_def.i_Enable = 1'b0;
    repeat (5) begin
      tick();
      chk("stall.x",      32'(if_def.o_X), 0);
      chk("stall.y",      32'(if_def.o_Y), 1);
      chk("stall.lstart", 32'(if_def.o_LineStart), 1);
    end
    if_def.i_Enable = 1'b1;
    tick();
    chk("resume.x", 32'(if_def.o_X), 1);
    chk("resume.y", 32'(if_def.o_Y), 1);

    // small instance: enable toggled every cycle over two frames
    rst_sm = 1'b0;
    first_fs = -1;
    for (int c = 0; c < 480; c++) begin
      if_sm.i_Enable = (c % 2 == 0);
      if_sm.i_Video  = ((c / 3) % 2 == 0);
      tick();
      if (c % 2 == 0) sm_advance();
      sm_check_all("tog");
      if (first_fs < 0 && if_sm.o_FrameStart) first_fs = c;
    end
    chk("tog.first_fstart", first_fs, 238);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("tog.fcount_end", 32'(if_sm.o_FrameCount), 2);
`endif

    // async reset from inside the blanking/sync region at (12,5)
    if_sm.i_Enable = 1'b1;
    if_sm.i_Video  = 1'b1;
    for (int i = 0; i < 200 && !(sx == 12 && sy == 5); i++) begin
      tick();
      sm_advance();
    end
    chk("pre_rst.x", 32'(if_sm.o_X), 12);
    chk("pre_rst.y", 32'(if_sm.o_Y), 5);
    chk("pre_rst.hsync", 32'(if_sm.o_HSync), 1);
    #2 rst_sm = 1'b1;
    #1;
    chk("arst.x",      32'(if_sm.o_X), 0);
    chk("arst.y",      32'(if_sm.o_Y), 0);
    chk("arst.active", 32'(if_sm.o_Active), 1);
    chk("arst.fstart", 32'(if_sm.o_FrameStart), 1);
    chk("arst.hsync",  32'(if_sm.o_HSync), 0);
    chk("arst.vsync",  32'(if_sm.o_VSync), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("arst.fcount", 32'(if_sm.o_FrameCount), 0);
`endif
    tick();
    chk("arst_hold.x", 32'(if_sm.o_X), 0);
    rst_sm = 1'b0;
    tick();
    chk("post_rst.x", 32'(if_sm.o_X), 1);
    chk("post_rst.y", 32'(if_sm.o_Y), 0);
    chk("post_rst.lstart", 32'(if_sm.o_LineStart), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameters: H_VISIBLE 640 (visible pixels/line); H_FRONT 16; H_SYNC 96; H_BACK 48 (porch/pulse pixels).
REQ-002 SHALL have parameters: V_VISIBLE 480 (visible lines); V_FRONT 10; V_SYNC 2; V_BACK 33 (porch/pulse lines).
REQ-003 SHALL have parameters: H_SYNC_POL 0, V_SYNC_POL 0 (active level of sync pulse); CNT_W 10 (coordinate width).
REQ-004 SHALL have ports: i_Clk in 1 clock; i_Reset in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: i_Enable in 1 pixel-clock enable; i_Video in 1 pixel data for current (o_X,o_Y).
REQ-006 SHALL have ports: o_X, o_Y out CNT_W current pixel coordinate; o_HSync, o_VSync out 1 sync.
REQ-007 SHALL have ports: o_HBlank, o_VBlank, o_Active out 1; o_LineStart, o_FrameStart out 1; o_Video out 1.
REQ-008 SHALL have port o_FrameCount out 16 frame counter, present only with VGA_SYNC_FRAME_CNT_EN.

Function
REQ-009 SHALL define H_TOTAL = sum of H_* and V_TOTAL = sum of V_*; counters zero-based.
REQ-010 SHALL advance o_X by 1 on each i_Clk rising edge with i_Enable=1; hold otherwise.
REQ-011 SHALL wrap o_X from H_TOTAL-1 to 0 and, on that same edge, advance o_Y; o_Y wraps V_TOTAL-1 -> 0.
REQ-012 SHALL register all outputs except o_Video; every output describes the pixel at (o_X,o_Y) in the same cycle, zero skew.
REQ-013 SHALL assert o_HBlank iff o_X >= H_VISIBLE; o_VBlank iff o_Y >= V_VISIBLE; o_Active = !o_HBlank & !o_VBlank.
REQ-014 SHALL drive o_HSync = H_SYNC_POL iff H_VISIBLE+H_FRONT <= o_X < H_VISIBLE+H_FRONT+H_SYNC, else inverted.
REQ-015 SHALL drive o_VSync = V_SYNC_POL iff V_VISIBLE+V_FRONT <= o_Y < V_VISIBLE+V_FRONT+V_SYNC, else inverted.
REQ-016 SHALL assert o_LineStart iff o_X==0; o_FrameStart iff o_X==0 and o_Y==0; both held while i_Enable=0.
REQ-017 SHALL drive o_Video = o_Active & i_Video combinationally; 0 whenever blanked.
REQ-018 SHALL reject at elaboration any zero-valued H_*/V_* timing parameter or H_TOTAL/V_TOTAL > 2^CNT_W.
REQ-019 SHALL freeze all registered outputs while i_Enable=0 for any number of cycles; resume without loss on re-enable.

Reset
REQ-020 SHALL, on i_Reset high, immediately force o_X=0, o_Y=0, independent of i_Clk and i_Enable.
REQ-021 SHALL reset outputs to: HSync=!H_SYNC_POL, VSync=!V_SYNC_POL, HBlank=0, VBlank=0, Active=1, LineStart=1, FrameStart=1.
REQ-022 SHALL, on reset mid-line or mid-frame, abandon the frame; first enabled edge after release moves to (1,0).

Configuration
REQ-023 SHALL, with VGA_SYNC_FRAME_CNT_EN defined, provide o_FrameCount: reset 0, +1 on each edge where (o_X,o_Y) wraps (H_TOTAL-1,V_TOTAL-1) -> (0,0), wraps 0xFFFF -> 0.
REQ-024 SHALL, without VGA_SYNC_FRAME_CNT_EN, omit o_FrameCount port and its register; all other behaviour identical.

Verification
REQ-025 SHALL cover: defaults, i_Enable=1, 800 edges from reset -> o_X back to 0, o_Y=1, o_LineStart pulses once per 800 cycles.
REQ-026 SHALL cover: defaults, sweep a line -> o_HSync=0 for o_X 656..751 only; o_HBlank=1 for o_X 640..799.
REQ-027 SHALL cover: defaults, full frame 420000 edges -> o_VSync=0 for o_Y 490..491, o_FrameStart at cycle 0 and 420000.
REQ-028 SHALL cover: i_Enable toggled 1/0 every cycle -> frame length doubles to 840000 cycles, outputs unchanged during stall cycles.
REQ-029 SHALL cover: i_Reset asserted asynchronously at (700,300) -> o_X=0,o_Y=0,o_Active=1 before next i_Clk edge.
REQ-030 SHALL cover: VGA_SYNC_FRAME_CNT_EN, H_SYNC_POL=1, i_Video=1 -> o_HSync high in pulse, o_Video=1 only when o_Active, o_FrameCount 0->1->2 over two frames.
